player_motion: RTL
==================

Name: player_motion

Overview:
- Position/motion controller for the blue character; the consumer end of the collision interface.
- Takes the 4-bit collision flags (bit0 feet on ground top, bit1 head on ground bottom, bit2 right side blocked, bit3 left side blocked) plus keyboard levels.
- Produces the x_blue/y_blue coordinates that the collision detector and renderer consume.
- Movement is paced by a frame tick; gravity, jump ascent and wall blocking are resolved by a 3-state FSM.

Parameters:
X_INIT, 10'd100, x_blue after reset
Y_INIT, 9'd300, y_blue after reset
X_MIN, 10'd0, leftmost allowed x_blue
X_MAX, 10'd617, rightmost allowed x_blue (640-23)
Y_MAX, 9'd435, floor y_blue (480-45); treated as solid ground
JUMP_HEIGHT, 7'd60, maximum ascent in pixels per jump

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
frame_tick  input  1  one-clk pulse; all motion updates happen only on this cycle; pulses are at least 2 clks apart
key_left  input  1  level, move left
key_right  input  1  level, move right
key_jump  input  1  level, jump request (edge-detected internally)
is_Collision  input  4  collision flags for the current x_blue/y_blue
x_blue  output  10  character left edge, pixels
y_blue  output  9  character top edge, pixels, y grows downward
state  output  2  00 STAND, 01 RISE, 10 FALL
on_ground  output  1  high iff state==STAND

Behaviour:
- Reset (async, rst=1): x_blue=X_INIT, y_blue=Y_INIT, state=FALL, on_ground=0, rise_cnt=0, jump_pending=0, key_jump_d=0.
- Jump capture:
  - key_jump_d registers key_jump every clk.
  - Rising edge (key_jump & ~key_jump_d) sets jump_pending.
  - jump_pending clears on every frame_tick cycle, whether consumed or not.
  - An edge on the same cycle as frame_tick counts for that tick.
- Horizontal (on frame_tick only):
  - key_left & ~key_right: x_blue-1 if ~is_Collision[3] and x_blue>X_MIN.
  - key_right & ~key_left: x_blue+1 if ~is_Collision[2] and x_blue<X_MAX.
  - Both or neither pressed: no change.
  - x_blue never leaves [X_MIN,X_MAX]; no wrap.
- Vertical FSM (evaluated on frame_tick only; between ticks all state holds):
  - STAND:
    - If ~is_Collision[0] and y_blue!=Y_MAX: go to FALL, no y change this tick.
    - Else if jump pending: go to RISE, rise_cnt=0, no y change this tick.
    - Else stay.
  - RISE:
    - If is_Collision[1], rise_cnt==JUMP_HEIGHT, or y_blue==0: go to FALL, no y change this tick.
    - Else y_blue-1, rise_cnt+1.
    - Head-bump takes priority over counting.
  - FALL:
    - If is_Collision[0] or y_blue==Y_MAX: go to STAND, no y change.
    - Else y_blue+1.
  - Encoding 11 is illegal; recover to FALL on the next tick.
- Horizontal and vertical updates in one tick are independent and use the same sampled is_Collision. Diagonal motion is allowed.
- Latency: position registers change on the clk edge ending the frame_tick cycle. Outputs are registered; on_ground is decoded from the registered state.
- Flags are interpreted as valid for the current position. The 2-clk minimum tick spacing gives the registered detector time to update.
- Reset mid-jump: immediate return to reset values; jump_pending is discarded.

Test Plan:
1. Release rst with is_Collision=0, then 10 ticks -> state=FALL, y_blue 300→310, x_blue=100, on_ground=0.
2. From case 1, assert is_Collision[0] before a tick -> that tick: state=STAND, y_blue unchanged at 310, on_ground=1. Next 5 ticks: y stays 310.
3. STAND, pulse key_jump one clk between ticks, flags stay bit0=1 -> tick1 enters RISE. Ticks 2..61 give y 310→250. Tick 62 gives FALL. Holding key_jump high after landing does not re-jump.
4. RISE at y=280, assert is_Collision[1] -> next tick: state=FALL, y stays 280. Following tick y=281.
5. key_right held 5 ticks with is_Collision[2]=1 on ticks 3-5 -> x 100→102 then holds. key_left+key_right together -> x unchanged. At x=617 with key_right -> x stays 617.
6. Assert rst mid-RISE (y=270) -> same-cycle async: x=100, y=300, state=FALL. A jump_pending set before reset does not cause a jump after landing.

Source files
------------

// File: rtl/player_motion.sv
// player_motion: frame-paced position controller for the blue character.
// Consumes collision flags for the current position and keyboard levels,
// and resolves gravity, jump ascent and wall blocking with a 3-state FSM.
module player_motion #(
   parameter logic [9:0] X_INIT      = 10'd100,
   parameter logic [8:0] Y_INIT      = 9'd300,
   parameter logic [9:0] X_MIN       = 10'd0,
   parameter logic [9:0] X_MAX       = 10'd617,
   parameter logic [8:0] Y_MAX       = 9'd435,
   parameter logic [6:0] JUMP_HEIGHT = 7'd60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_jump,
   input  logic [3:0] is_Collision,
   output logic [9:0] x_blue,
   output logic [8:0] y_blue,
   output logic [1:0] state,
   output logic       on_ground
);

   localparam logic [1:0] ST_STAND = 2'b00;
   localparam logic [1:0] ST_RISE  = 2'b01;
   localparam logic [1:0] ST_FALL  = 2'b10;

   logic [1:0] state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [8:0] y_q, y_d;
   logic [6:0] rise_cnt_q, rise_cnt_d;
   logic       jump_pending_q, jump_pending_d;
   logic       key_jump_q;

   logic jump_edge;
   logic jump_req;
   logic feet_hit;
   logic head_hit;
   logic right_blk;
   logic left_blk;

   assign feet_hit  = is_Collision[0];
   assign head_hit  = is_Collision[1];
   assign right_blk = is_Collision[2];
   assign left_blk  = is_Collision[3];

   // An edge arriving on the tick cycle itself is honoured by that tick.
   assign jump_edge = key_jump & ~key_jump_q;
   assign jump_req  = jump_pending_q | jump_edge;

   // State and datapath registers, all returned to start values by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_FALL;
         x_q            <= X_INIT;
         y_q            <= Y_INIT;
         rise_cnt_q     <= 7'd0;
         jump_pending_q <= 1'b0;
         key_jump_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         x_q            <= x_d;
         y_q            <= y_d;
         rise_cnt_q     <= rise_cnt_d;
         jump_pending_q <= jump_pending_d;
         key_jump_q     <= key_jump;
      end
   end

   // Jump latch: set by an edge, dropped on every tick whether used or not.
   always_comb begin
      jump_pending_d = jump_pending_q;
      if (frame_tick) begin
         jump_pending_d = 1'b0;
      end else if (jump_edge) begin
         jump_pending_d = 1'b1;
      end
   end

   // Vertical FSM next state, only advanced on a frame tick.
   always_comb begin
      state_d = state_q;
      if (frame_tick) begin
         case (state_q)
            ST_STAND: begin
               if (!feet_hit && (y_q != Y_MAX)) begin
                  state_d = ST_FALL;
               end else if (jump_req) begin
                  state_d = ST_RISE;
               end
            end
            ST_RISE: begin
               if (head_hit || (rise_cnt_q == JUMP_HEIGHT) || (y_q == 9'd0)) begin
                  state_d = ST_FALL;
               end
            end
            ST_FALL: begin
               if (feet_hit || (y_q == Y_MAX)) begin
                  state_d = ST_STAND;
               end
            end
            default: state_d = ST_FALL;
         endcase
      end
   end

   // Vertical position and ascent counter; transitions never move y.
   always_comb begin
      y_d        = y_q;
      rise_cnt_d = rise_cnt_q;
      if (frame_tick) begin
         case (state_q)
            ST_STAND: begin
               if ((feet_hit || (y_q == Y_MAX)) && jump_req) begin
                  rise_cnt_d = 7'd0;
               end
            end
            ST_RISE: begin
               if (!(head_hit || (rise_cnt_q == JUMP_HEIGHT) || (y_q == 9'd0))) begin
                  y_d        = y_q - 9'd1;
                  rise_cnt_d = rise_cnt_q + 7'd1;
               end
            end
            ST_FALL: begin
               if (!(feet_hit || (y_q == Y_MAX))) begin
                  y_d = y_q + 9'd1;
               end
            end
            default: begin
               y_d = y_q;
            end
         endcase
      end
   end

   // Horizontal step, independent of the vertical FSM, clamped to the screen.
   always_comb begin
      x_d = x_q;
      if (frame_tick) begin
         if (key_left && !key_right && !left_blk && (x_q > X_MIN)) begin
            x_d = x_q - 10'd1;
         end else if (key_right && !key_left && !right_blk && (x_q < X_MAX)) begin
            x_d = x_q + 10'd1;
         end
      end
   end

   // Outputs are straight from registers; on_ground decodes registered state.
   always_comb begin
      x_blue    = x_q;
      y_blue    = y_q;
      state     = state_q;
      on_ground = (state_q == ST_STAND);
   end

endmodule
